// File: rtl/wb_arbiter.sv
// Write-back arbiter for the 4-thread register file: merges unstallable pipeline
// results with FIFO-buffered accelerator returns into one registered write port.
module wb_arbiter #(
    parameter int D_WIDTH      = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pipe_valid,
    input  logic [4:0]         pipe_rd,
    input  logic [3:0]         pipe_thread,
    input  logic [D_WIDTH-1:0] pipe_data,
    input  logic               acc_valid,
    output logic               acc_ready,
    input  logic [4:0]         acc_rd,
    input  logic [3:0]         acc_thread,
    input  logic [D_WIDTH-1:0] acc_data,
    output logic               stall_req,
    output logic               ctrl_WB,
    output logic [4:0]         reg_wraddr,
    output logic [3:0]         thread_sel_WB,
    output logic [D_WIDTH-1:0] data_WB,
    output logic [1:0]         err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    function automatic logic is_onehot(input logic [3:0] t);
        return (t != 4'd0) && ((t & (t - 4'd1)) == 4'd0);
    endfunction

    logic [4:0]         fifo_rd     [FIFO_DEPTH];
    logic [3:0]         fifo_thread [FIFO_DEPTH];
    logic [D_WIDTH-1:0] fifo_data   [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [SW-1:0]      starve_cnt;

    logic fifo_full;
    logic fifo_nonempty;
    logic acc_fire;
    logic push;
    logic acc_bad;
    logic pipe_live;
    logic pipe_win;
    logic pipe_bad;
    logic pipe_drop;
    logic pop;

    assign fifo_full     = (count == CW'(FIFO_DEPTH));
    assign fifo_nonempty = (count != '0);
    assign acc_ready     = !fifo_full;
    assign stall_req     = (starve_cnt == SW'(STARVE_LIMIT)) && fifo_nonempty;

    // pipe_win already excludes stall cycles, so a forced pop falls out of !pipe_win
    always_comb begin
        acc_fire  = acc_valid && acc_ready;
        push      = acc_fire && (acc_rd != 5'd0) && is_onehot(acc_thread);
        acc_bad   = acc_fire && !is_onehot(acc_thread);
        pipe_live = pipe_valid && !stall_req && (pipe_rd != 5'd0);
        pipe_win  = pipe_live && is_onehot(pipe_thread);
        pipe_bad  = pipe_live && !is_onehot(pipe_thread);
        pipe_drop = pipe_valid && stall_req;
        pop       = fifo_nonempty && !pipe_win;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]     <= acc_rd;
            fifo_thread[wr_ptr] <= acc_thread;
            fifo_data[wr_ptr]   <= acc_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (pop || !fifo_nonempty)
                starve_cnt <= '0;
            else if (pipe_win && (starve_cnt != SW'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Address, thread and data hold their last values on idle cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_WB       <= 1'b0;
            reg_wraddr    <= '0;
            thread_sel_WB <= '0;
            data_WB       <= '0;
            err           <= '0;
        end else begin
            err <= err | {(acc_bad || pipe_bad), pipe_drop};
            if (pipe_win) begin
                ctrl_WB       <= 1'b1;
                reg_wraddr    <= pipe_rd;
                thread_sel_WB <= pipe_thread;
                data_WB       <= pipe_data;
            end else if (pop) begin
                ctrl_WB       <= 1'b1;
                reg_wraddr    <= fifo_rd[rd_ptr];
                thread_sel_WB <= fifo_thread[rd_ptr];
                data_WB       <= fifo_data[rd_ptr];
            end else begin
                ctrl_WB <= 1'b0;
            end
        end
    end

endmodule
